pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Instruction sequencer for picoMIPS; sits on the consumer side of the program counter.
- Takes the instruction word fetched from program memory (combinational ROM addressed by the PC) and decodes the opcode.
- Drives the PC's increment / relative-branch controls and branch offset.
- Sequences multi-cycle instructions: multiply wait and switch-input handshake. Also handles halt and keeps the zero flag.

Parameters:
Psize, 5, PC / branch-offset width; offset = instr[Psize-1:0], two's complement
Isize, 24, instruction width; opcode = instr[Isize-1:Isize-4]
Csize, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, rising edge
nreset  input  1  asynchronous active-low reset
instr  input  Isize  current instruction word from program ROM (combinational on PC)
z_in  input  1  ALU zero result for current ALU instruction
mul_done  input  1  multiplier result valid
sw_valid  input  1  switch-input data valid
PCincr  output  1  to PC: advance by 1
PCrelbranch  output  1  to PC: add Branchaddr
Branchaddr  output  Psize  relative branch offset, = instr[Psize-1:0] at all times
reg_we  output  1  register-file write enable
mul_start  output  1  one-cycle multiplier start pulse
sw_ready  output  1  sequencer ready to accept switch data
halted  output  1  core stopped
retired  output  Csize  count of completed instructions, saturating

Behaviour:
- Reset: asynchronous, active-low, on nreset only. State=RUN, zflag=0, retired=0.
  - All control outputs are deasserted in reset: PCincr, PCrelbranch, reg_we, mul_start, sw_ready, halted all 0.
  - Reset mid-MULW/INW/HALTED aborts to RUN with no write and no PC move.
- Control outputs are combinational from state and instr; state, zflag and retired are registered.
- Invariant: PCincr & PCrelbranch is never 1.
- Opcodes: 0000 NOP, 0001 ALU, 0010 MUL, 0011 INSW, 0100 BEQ, 0101 BNE, 0110 BRA, 0111 HALT; 1000-1111 decode as NOP.
- State RUN:
  - NOP: PCincr=1.
  - ALU: reg_we=1, PCincr=1; zflag<=z_in at the clock edge.
  - BEQ: if zflag then PCrelbranch=1, else PCincr=1.
  - BNE: the inverse of BEQ.
  - BRA: PCrelbranch=1. An offset of 0 spins on the same PC and is legal.
  - MUL: mul_start=1, no PC move, next state MULW.
  - INSW: no PC move, next state INW.
  - HALT: no PC move, next state HALTED.
- State MULW:
  - mul_start=0.
  - mul_done=0: hold, no outputs.
  - mul_done=1: reg_we=1, PCincr=1, next state RUN.
  - mul_done is ignored while in RUN, including the mul_start cycle.
- State INW:
  - sw_ready=1.
  - sw_valid=1: transfer. reg_we=1, PCincr=1, next state RUN; sw_ready drops the next cycle.
  - sw_valid=0: hold.
  - sw_valid seen in RUN is ignored.
- State HALTED: halted=1, all other controls 0. Exit only by reset.
- zflag changes only on ALU completion. MUL and INSW do not touch it.
- retired: +1 on every cycle where PCincr or PCrelbranch=1. It saturates at all-ones and does not wrap.
- PC wrap-around (mod 2^Psize) is the PC's responsibility; Branchaddr is passed unmodified.

Test Plan:
- Reset, then NOP, ALU (z_in=1), BEQ off=5'b00011 -> cycle 0 PCincr; cycle 1 reg_we=1, PCincr; cycle 2 PCrelbranch=1, Branchaddr=3, retired=3.
- ALU z_in=0, then BEQ off=3 -> BEQ cycle PCincr=1. Same sequence with BNE -> PCrelbranch=1. Offset 5'b11110 (-2) -> Branchaddr=5'b11110.
- MUL, mul_done asserted 4 cycles after mul_start -> mul_start high exactly 1 cycle; no PC controls for 4 cycles; reg_we and PCincr together on the 5th cycle; retired +1 only.
- INSW with sw_valid low 3 cycles then high -> sw_ready=1 for 4 cycles; reg_we and PCincr in the 4th. sw_valid pulsed during RUN beforehand -> no effect.
- HALT, then 10 cycles of arbitrary instr/mul_done/sw_valid -> halted=1, no PC/reg controls. Pulse nreset low mid-cycle -> outputs clear immediately, RUN resumes.
- Csize=3 build, 9 NOPs -> retired saturates at 7. Reset asserted during MULW -> no reg_we, zflag=0, retired=0.

Source files
------------

// File: rtl/pc_seq.sv
// Instruction sequencer for picoMIPS: decodes the ROM word and drives the PC, register-file write and multi-cycle handshakes.
// Latency: control outputs are combinational from state and instr; state, zero flag and retired count update on the next rising edge.
// Backpressure: MUL and INSW stall the PC until mul_done or sw_valid arrives; HALT stalls it until nreset.
//
// Ports:
//   clk, nreset      - rising-edge clock, asynchronous active-low reset
//   instr            - instruction word from the program ROM (combinational on PC)
//   z_in             - ALU zero result for the current ALU instruction
//   mul_done         - multiplier result valid (only honoured while waiting on MUL)
//   sw_valid         - switch data valid (only honoured while waiting on INSW)
//   PCincr           - PC advances by one
//   PCrelbranch      - PC adds Branchaddr
//   Branchaddr       - signed branch offset, always instr[Psize-1:0]
//   reg_we           - register-file write enable
//   mul_start        - one-cycle multiplier start pulse
//   sw_ready         - sequencer waiting for switch data
//   halted           - core stopped until reset
//   retired          - saturating count of instructions that moved the PC
module pc_seq #(
    parameter int Psize = 5,
    parameter int Isize = 24,
    parameter int Csize = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [Isize-1:0] instr,
    input  logic             z_in,
    input  logic             mul_done,
    input  logic             sw_valid,
    output logic             PCincr,
    output logic             PCrelbranch,
    output logic [Psize-1:0] Branchaddr,
    output logic             reg_we,
    output logic             mul_start,
    output logic             sw_ready,
    output logic             halted,
    output logic [Csize-1:0] retired
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULW   = 2'd1,
        ST_INW    = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ALU  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_INSW = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_BRA  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b0111;

    localparam logic [Csize-1:0] RETIRED_ONE = {{(Csize-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             zflag_q, zflag_d;
    logic [Csize-1:0] retired_q, retired_d;

    logic [3:0]       opcode;
    logic             incr_raw, rel_raw, we_raw, mstart_raw, sready_raw, halt_raw;
    logic             unused_bits;

    assign opcode      = instr[Isize-1:Isize-4];
    assign Branchaddr  = instr[Psize-1:0];
    // Bits between the opcode and the offset carry register fields for the datapath.
    assign unused_bits = ^instr[Isize-5:Psize];

    // Next-state and raw control decode.
    always_comb begin
        state_d    = state_q;
        zflag_d    = zflag_q;
        incr_raw   = 1'b0;
        rel_raw    = 1'b0;
        we_raw     = 1'b0;
        mstart_raw = 1'b0;
        sready_raw = 1'b0;
        halt_raw   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                unique case (opcode)
                    OP_ALU: begin
                        we_raw   = 1'b1;
                        incr_raw = 1'b1;
                        zflag_d  = z_in;
                    end
                    OP_MUL: begin
                        // mul_done is deliberately not looked at here, even in the start cycle.
                        mstart_raw = 1'b1;
                        state_d    = ST_MULW;
                    end
                    OP_INSW: begin
                        state_d = ST_INW;
                    end
                    OP_BEQ: begin
                        rel_raw  = zflag_q;
                        incr_raw = ~zflag_q;
                    end
                    OP_BNE: begin
                        rel_raw  = ~zflag_q;
                        incr_raw = zflag_q;
                    end
                    OP_BRA: begin
                        // Offset 0 simply re-executes the same PC forever.
                        rel_raw = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = ST_HALTED;
                    end
                    default: begin
                        // OP_NOP and all unassigned opcodes 1000-1111.
                        incr_raw = 1'b1;
                    end
                endcase
            end
            ST_MULW: begin
                if (mul_done) begin
                    we_raw   = 1'b1;
                    incr_raw = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_INW: begin
                sready_raw = 1'b1;
                if (sw_valid) begin
                    we_raw   = 1'b1;
                    incr_raw = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                // ST_HALTED: only reset leaves this state.
                halt_raw = 1'b1;
            end
        endcase
    end

    // Outputs are qualified by nreset so that asserting reset mid-cycle silences
    // the PC and register file at once, not just at the next edge.
    always_comb begin
        PCincr      = incr_raw & nreset;
        PCrelbranch = rel_raw & nreset;
        reg_we      = we_raw & nreset;
        mul_start   = mstart_raw & nreset;
        sw_ready    = sready_raw & nreset;
        halted      = halt_raw & nreset;
    end

    // Count every cycle that moves the PC; stick at all-ones.
    always_comb begin
        retired_d = retired_q;
        if ((PCincr | PCrelbranch) && (retired_q != {Csize{1'b1}})) begin
            retired_d = retired_q + RETIRED_ONE;
        end
    end

    assign retired = retired_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_RUN;
            zflag_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            zflag_q   <= zflag_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios with literal expectations, then randomized traffic.
// Latency: one instruction decision per clock; outputs compared on the falling edge.
// Backpressure: the bench drives mul_done / sw_valid at random to exercise the wait states.
module tb_pc_seq;

    localparam int PS  = 5;
    localparam int IS  = 24;
    localparam int CS  = 16;
    localparam int CS3 = 3;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [IS-1:0] instr = '0;
    logic          z_in = 1'b0;
    logic          mul_done = 1'b0;
    logic          sw_valid = 1'b0;

    logic          pc_incr, pc_rel, reg_we, mul_start, sw_ready, halted;
    logic [PS-1:0] br_addr;
    logic [CS-1:0] retired;

    logic          b_incr, b_rel, b_we, b_mstart, b_sready, b_halted;
    logic [PS-1:0] b_addr;
    logic [CS3-1:0] b_retired;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending-wait flags, zero flag and an unbounded retire count.
    bit m_wait_mul, m_wait_sw, m_halt, m_z;
    int m_cnt;
    bit n_wait_mul, n_wait_sw, n_halt, n_z;
    int n_cnt;
    bit e_incr, e_rel, e_we, e_ms, e_sr, e_h;

    pc_seq #(.Psize(PS), .Isize(IS), .Csize(CS)) dut (
        .clk(clk), .nreset(nreset), .instr(instr), .z_in(z_in),
        .mul_done(mul_done), .sw_valid(sw_valid),
        .PCincr(pc_incr), .PCrelbranch(pc_rel), .Branchaddr(br_addr),
        .reg_we(reg_we), .mul_start(mul_start), .sw_ready(sw_ready),
        .halted(halted), .retired(retired)
    );

    pc_seq #(.Psize(PS), .Isize(IS), .Csize(CS3)) dut3 (
        .clk(clk), .nreset(nreset), .instr(instr), .z_in(z_in),
        .mul_done(mul_done), .sw_valid(sw_valid),
        .PCincr(b_incr), .PCrelbranch(b_rel), .Branchaddr(b_addr),
        .reg_we(b_we), .mul_start(b_mstart), .sw_ready(b_sready),
        .halted(b_halted), .retired(b_retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IS-1:0] mk(input logic [3:0] op, input logic [PS-1:0] off);
        logic [14:0] mid;
        mid = 15'($urandom);
        return {op, mid, off};
    endfunction

    function automatic int sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_wait_mul = 0; m_wait_sw = 0; m_halt = 0; m_z = 0; m_cnt = 0;
        n_wait_mul = 0; n_wait_sw = 0; n_halt = 0; n_z = 0; n_cnt = 0;
    endtask

    // Falling edge: derive expected outputs from the instruction rules and compare.
    task automatic eval_cycle();
        logic [3:0] op;
        @(negedge clk);
        {e_incr, e_rel, e_we, e_ms, e_sr, e_h} = '0;
        if (!nreset) begin
            model_reset();
        end else begin
            n_wait_mul = m_wait_mul; n_wait_sw = m_wait_sw; n_halt = m_halt; n_z = m_z;
            op = instr[IS-1:IS-4];
            if (m_halt) begin
                e_h = 1;
            end else if (m_wait_mul) begin
                if (mul_done) begin e_we = 1; e_incr = 1; n_wait_mul = 0; end
            end else if (m_wait_sw) begin
                e_sr = 1;
                if (sw_valid) begin e_we = 1; e_incr = 1; n_wait_sw = 0; end
            end else begin
                if (op == 4'd1) begin e_we = 1; e_incr = 1; n_z = z_in; end
                else if (op == 4'd2) begin e_ms = 1; n_wait_mul = 1; end
                else if (op == 4'd3) n_wait_sw = 1;
                else if (op == 4'd4) begin e_rel = m_z; e_incr = !m_z; end
                else if (op == 4'd5) begin e_rel = !m_z; e_incr = m_z; end
                else if (op == 4'd6) e_rel = 1;
                else if (op == 4'd7) n_halt = 1;
                else e_incr = 1;
            end
            n_cnt = m_cnt + ((e_incr || e_rel) ? 1 : 0);
        end
        check("PCincr", 32'(pc_incr), 32'(e_incr));
        check("PCrelbranch", 32'(pc_rel), 32'(e_rel));
        check("reg_we", 32'(reg_we), 32'(e_we));
        check("mul_start", 32'(mul_start), 32'(e_ms));
        check("sw_ready", 32'(sw_ready), 32'(e_sr));
        check("halted", 32'(halted), 32'(e_h));
        check("Branchaddr", 32'(br_addr), 32'(instr[PS-1:0]));
        check("retired", 32'(retired), 32'(sat(m_cnt, CS)));
        check("retired3", 32'(b_retired), 32'(sat(m_cnt, CS3)));
        check("PCincr3", 32'(b_incr), 32'(e_incr));
        check("halted3", 32'(b_halted), 32'(e_h));
    endtask

    task automatic commit();
        @(posedge clk);
        if (nreset) begin
            m_wait_mul = n_wait_mul; m_wait_sw = n_wait_sw; m_halt = n_halt; m_z = n_z; m_cnt = n_cnt;
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [PS-1:0] off,
                         input logic z, input logic md, input logic sv);
        instr = mk(op, off); z_in = z; mul_done = md; sw_valid = sv;
    endtask

    task automatic step(input logic [3:0] op, input logic [PS-1:0] off,
                        input logic z, input logic md, input logic sv);
        drive(op, off, z, md, sv);
        eval_cycle();
        commit();
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        drive(4'd0, '0, 0, 0, 0);
        eval_cycle();
        commit();
        nreset = 1'b1;
    endtask

    initial begin
        int halt_cycles;
        model_reset();

        // Reset state.
        drive(4'd0, '0, 0, 0, 0);
        eval_cycle();
        check("lit_reset_incr", 32'(pc_incr), 32'd0);
        check("lit_reset_retired", 32'(retired), 32'd0);
        commit();
        nreset = 1'b1;

        // NOP, ALU z=1, BEQ +3.
        drive(4'd0, 5'd0, 0, 0, 0); eval_cycle();
        check("lit_nop_incr", 32'(pc_incr), 32'd1);
        commit();
        drive(4'd1, 5'd0, 1, 0, 0); eval_cycle();
        check("lit_alu_we", 32'({reg_we, pc_incr}), 32'b11);
        commit();
        drive(4'd4, 5'b00011, 0, 0, 0); eval_cycle();
        check("lit_beq_taken", 32'({pc_rel, pc_incr}), 32'b10);
        check("lit_beq_addr", 32'(br_addr), 32'd3);
        commit();
        check("lit_retired3", 32'(retired), 32'd3);

        // zflag cleared: BEQ falls through, BNE branches, negative offset passes through.
        step(4'd1, 5'd0, 0, 0, 0);
        drive(4'd4, 5'd3, 0, 0, 0); eval_cycle();
        check("lit_beq_fall", 32'({pc_rel, pc_incr}), 32'b01);
        commit();
        step(4'd1, 5'd0, 0, 0, 0);
        drive(4'd5, 5'd3, 0, 0, 0); eval_cycle();
        check("lit_bne_taken", 32'({pc_rel, pc_incr}), 32'b10);
        commit();
        drive(4'd6, 5'b11110, 0, 0, 0); eval_cycle();
        check("lit_bra_neg", 32'({pc_rel, br_addr}), 32'b1_11110);
        commit();

        // MUL: done pulse in the start cycle is ignored; completes 4 cycles later.
        drive(4'd2, 5'd0, 0, 1, 0); eval_cycle();
        check("lit_mul_start", 32'({mul_start, pc_incr, pc_rel}), 32'b100);
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(4'd0, 5'd0, 0, 0, 0); eval_cycle();
            check("lit_mulw_idle", 32'({mul_start, pc_incr, pc_rel, reg_we}), 32'b0);
            commit();
        end
        drive(4'd0, 5'd0, 0, 1, 0); eval_cycle();
        check("lit_mul_done", 32'({reg_we, pc_incr}), 32'b11);
        commit();
        check("lit_mul_retired", 32'(retired), 32'd9);

        // INSW: sw_valid during RUN does nothing; then 3 idle waits and a transfer.
        step(4'd0, 5'd0, 0, 0, 1);
        step(4'd3, 5'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(4'd0, 5'd0, 0, 0, 0); eval_cycle();
            check("lit_inw_wait", 32'({sw_ready, reg_we, pc_incr}), 32'b100);
            commit();
        end
        drive(4'd0, 5'd0, 0, 0, 1); eval_cycle();
        check("lit_inw_xfer", 32'({sw_ready, reg_we, pc_incr}), 32'b111);
        commit();
        drive(4'd0, 5'd0, 0, 0, 0); eval_cycle();
        check("lit_inw_drop", 32'(sw_ready), 32'd0);
        commit();

        // HALT then garbage; mid-cycle reset clears outputs at once.
        step(4'd7, 5'd0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(4'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            eval_cycle();
            check("lit_halted", 32'({halted, pc_incr, pc_rel, reg_we}), 32'b1000);
            commit();
        end
        nreset = 1'b0;
        #1;
        check("lit_async_clear", 32'({halted, pc_incr, reg_we}), 32'b0);
        eval_cycle();
        commit();
        nreset = 1'b1;
        drive(4'd0, 5'd0, 0, 0, 0); eval_cycle();
        check("lit_run_resume", 32'(pc_incr), 32'd1);
        commit();

        // Saturation on the 3-bit instance.
        do_reset();
        for (int i = 0; i < 9; i++) step(4'd0, 5'd0, 0, 0, 0);
        check("lit_sat3", 32'(b_retired), 32'd7);
        check("lit_nosat16", 32'(retired), 32'd9);

        // Reset during MULW: no write, zflag and count cleared.
        step(4'd1, 5'd0, 1, 0, 0);
        step(4'd2, 5'd0, 0, 0, 0);
        step(4'd0, 5'd0, 0, 0, 0);
        nreset = 1'b0;
        drive(4'd0, 5'd0, 0, 1, 0);
        eval_cycle();
        check("lit_rst_mulw_we", 32'(reg_we), 32'd0);
        commit();
        nreset = 1'b1;
        check("lit_rst_retired", 32'(retired), 32'd0);
        drive(4'd4, 5'd2, 0, 0, 0); eval_cycle();
        check("lit_rst_zflag", 32'({pc_rel, pc_incr}), 32'b01);
        commit();

        // Randomized traffic.
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if (halt_cycles > 6 || $urandom_range(199) == 0) begin
                halt_cycles = 0;
                do_reset();
            end else begin
                step(4'($urandom), 5'($urandom), 1'($urandom),
                     ($urandom_range(3) == 0), ($urandom_range(9) < 3));
                if (m_halt) halt_cycles++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
